// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
// Shared declarations for the multi-port register file: the clear/ready
// state encoding used by the clear sequencer.
package regfile_mp_pkg;

    // CLEAR: storage is being zeroed one address per cycle; READY: idle, writes accepted
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bus between decode/writeback (master) and the register file (slave).
// Signals:
//   clr_req  master->slave  one-cycle clear request (honoured while ready=1)
//   regwrite master->slave  write enable
//   wa, wd   master->slave  write address / data
//   ra       master->slave  packed read addresses, port i = ra[i*REGBITS +: REGBITS]
//   ready    slave->master  1 = idle, 0 = clearing
//   rd       slave->master  packed read data, port i = rd[i*WIDTH +: WIDTH]
//   wr_drop  slave->master  pulse: previous cycle's write was discarded
interface regfile_mp_if #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int NREAD   = 2
);
    logic                       clr_req;
    logic                       regwrite;
    logic [REGBITS-1:0]         wa;
    logic [WIDTH-1:0]           wd;
    logic [NREAD*REGBITS-1:0]   ra;
    logic                       ready;
    logic [NREAD*WIDTH-1:0]     rd;
    logic                       wr_drop;

    modport master (
        output clr_req, regwrite, wa, wd, ra,
        input  ready, rd, wr_drop
    );

    modport slave (
        input  clr_req, regwrite, wa, wd, ra,
        output ready, rd, wr_drop
    );
endinterface

// File: rtl/regfile_mp_clear_fsm.sv
// regfile_mp_clear_fsm
// Clear sequencer: walks every address once after reset or on request,
// then reports ready. Also flags writes that arrive while not ready.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   i_clr_req       clear request (only honoured in READY)
//   i_regwrite      write enable from the bus (for drop detection)
//   o_ready         registered ready flag
//   o_wr_drop       registered pulse for a discarded write
//   o_clr_we        storage clear strobe for the current cycle
//   o_clr_addr      address being cleared
module regfile_mp_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_clr_req,
    input  logic               i_regwrite,
    output logic               o_ready,
    output logic               o_wr_drop,
    output logic               o_clr_we,
    output logic [REGBITS-1:0] o_clr_addr
);
    // Last address is all ones, so the counter wraps naturally back to 0
    localparam logic [REGBITS-1:0] L_LAST = {REGBITS{1'b1}};
    localparam logic [REGBITS-1:0] L_ONE  = REGBITS'(1'b1);

    state_e             r_state;
    logic [REGBITS-1:0] r_clr_cnt;
    logic               r_ready;
    logic               r_wr_drop;

    // State, clear counter, ready flag and drop pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= {REGBITS{1'b0}};
            r_ready   <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= i_regwrite & ~r_ready;
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == L_LAST) begin
                        r_state   <= ST_READY;
                        r_clr_cnt <= {REGBITS{1'b0}};
                        r_ready   <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + L_ONE;
                    end
                end
                ST_READY: begin
                    if (i_clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= {REGBITS{1'b0}};
                        r_ready   <= 1'b0;
                    end else begin
                        r_state   <= ST_READY;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= {REGBITS{1'b0}};
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Reset itself must not touch storage, so the clear strobe is gated by reset_n
    assign o_clr_we   = reset_n & (r_state == ST_CLEAR);
    assign o_clr_addr = r_clr_cnt;
    assign o_ready    = r_ready;
    assign o_wr_drop  = r_wr_drop;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-read-port register file with hardware clear, optional write-to-read
// bypass and a ready handshake. Register 0 always reads 0.
// Ports:
//   clk      single clock, all state updates on posedge
//   reset_n  synchronous active-low reset
//   bus      regfile_mp_if slave modport (clr_req, regwrite, wa, wd, ra -> ready, rd, wr_drop)
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int NREAD   = 2,
    parameter bit BYPASS  = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    regfile_mp_if.slave   bus
);
    localparam int NREGS = 1 << REGBITS;

    logic [WIDTH-1:0]   r_regs [NREGS];
    logic               w_ready;
    logic               w_wr_drop;
    logic               w_clr_we;
    logic [REGBITS-1:0] w_clr_addr;
    logic               w_wr_en;

    regfile_mp_clear_fsm #(
        .REGBITS (REGBITS)
    ) u_clear_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr_req  (bus.clr_req),
        .i_regwrite (bus.regwrite),
        .o_ready    (w_ready),
        .o_wr_drop  (w_wr_drop),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Writes to register 0 are dropped silently; they never count as a drop
    assign w_wr_en = w_ready & bus.regwrite & (bus.wa != {REGBITS{1'b0}});

    // Storage write mux; clear has priority (it is never active together with w_wr_en)
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_regs[w_clr_addr] <= {WIDTH{1'b0}};
        end else if (w_wr_en) begin
            r_regs[bus.wa] <= bus.wd;
        end else begin
            r_regs[w_clr_addr] <= r_regs[w_clr_addr];
        end
    end

    assign bus.ready   = w_ready;
    assign bus.wr_drop = w_wr_drop;

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [REGBITS-1:0] w_ra;
        logic [WIDTH-1:0]   w_rd;

        assign w_ra = bus.ra[gi*REGBITS +: REGBITS];

        // Per-port read mux: zero register and clearing read 0, then bypass, then storage
        always_comb begin
            w_rd = {WIDTH{1'b0}};
            if (w_ra == {REGBITS{1'b0}}) begin
                w_rd = {WIDTH{1'b0}};
            end else if (!w_ready) begin
                w_rd = {WIDTH{1'b0}};
            end else if (BYPASS && bus.regwrite && (bus.wa == w_ra)) begin
                w_rd = bus.wd;
            end else begin
                w_rd = r_regs[w_ra];
            end
        end

        assign bus.rd[gi*WIDTH +: WIDTH] = w_rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share stimulus, one with BYPASS=0/NREAD=2
// and one with BYPASS=1/NREAD=3. Expected values are queued when stimulus is
// driven and compared shortly after, away from the active clock edge.
module tb_regfile_mp;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clr_req;
    logic       regwrite;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [8:0] ra;          // {port2, port1, port0}; instance 0 sees the low 6 bits

    int checks = 0;
    int errors = 0;
    string phase = "init";

    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(8), .REGBITS(3), .NREAD(2)) bus0 ();
    regfile_mp_if #(.WIDTH(8), .REGBITS(3), .NREAD(3)) bus1 ();

    assign bus0.clr_req  = clr_req;
    assign bus0.regwrite = regwrite;
    assign bus0.wa       = wa;
    assign bus0.wd       = wd;
    assign bus0.ra       = ra[5:0];
    assign bus1.clr_req  = clr_req;
    assign bus1.regwrite = regwrite;
    assign bus1.wa       = wa;
    assign bus1.wd       = wd;
    assign bus1.ra       = ra;

    regfile_mp #(.WIDTH(8), .REGBITS(3), .NREAD(2), .BYPASS(1'b0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    regfile_mp #(.WIDTH(8), .REGBITS(3), .NREAD(3), .BYPASS(1'b1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [7:0]  wd;
        logic [8:0]  ra;
        logic [15:0] rd0;
        logic [23:0] rd1;
        logic        drop;
    } vec_t;

    vec_t vecs [9];

    string       name_q [$];
    int          tag_q  [$];
    logic [31:0] val_q  [$];

    function automatic logic [31:0] actual(int t);
        case (t)
            0:       return {31'd0, bus0.ready};
            1:       return {16'd0, bus0.rd};
            2:       return {31'd0, bus0.wr_drop};
            3:       return {31'd0, bus1.ready};
            4:       return {8'd0, bus1.rd};
            5:       return {31'd0, bus1.wr_drop};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_exp(string n, int t, logic [31:0] v);
        name_q.push_back(n);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic exp_status(logic rdy, logic drop);
        push_exp("ready0",   0, {31'd0, rdy});
        push_exp("wr_drop0", 2, {31'd0, drop});
        push_exp("ready1",   3, {31'd0, rdy});
        push_exp("wr_drop1", 5, {31'd0, drop});
    endtask

    task automatic exp_reads(logic [15:0] r0, logic [23:0] r1);
        push_exp("rd0", 1, {16'd0, r0});
        push_exp("rd1", 4, {8'd0, r1});
    endtask

    // Drain the scoreboard 1 time unit after the inputs settle
    task automatic check_all();
        string       n;
        int          t;
        logic [31:0] v;
        logic [31:0] a;
        #1;
        while (tag_q.size() != 0) begin
            n = name_q.pop_front();
            t = tag_q.pop_front();
            v = val_q.pop_front();
            a = actual(t);
            checks++;
            if (a !== v) begin
                errors++;
                $display("FAIL %s/%s: got %h expected %h", phase, n, a, v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        clr_req  = 1'b0;
        regwrite = 1'b0;
        wa       = 3'd0;
        wd       = 8'h00;
        ra       = 9'd0;

        //         we    wa    wd     ra {p2,p1,p0}          rd0       rd1          drop
        vecs[0] = '{1'b1, 3'd3, 8'hA5, {3'd0, 3'd0, 3'd3}, 16'h0000, 24'h0000A5, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 8'h00, {3'd0, 3'd3, 3'd3}, 16'hA5A5, 24'h00A5A5, 1'b0};
        vecs[2] = '{1'b1, 3'd0, 8'hFF, {3'd0, 3'd0, 3'd0}, 16'h0000, 24'h000000, 1'b0};
        vecs[3] = '{1'b0, 3'd0, 8'h00, {3'd0, 3'd0, 3'd0}, 16'h0000, 24'h000000, 1'b0};
        vecs[4] = '{1'b1, 3'd7, 8'h3C, {3'd7, 3'd7, 3'd1}, 16'h0000, 24'h3C3C00, 1'b0};
        vecs[5] = '{1'b1, 3'd1, 8'h5A, {3'd7, 3'd7, 3'd1}, 16'h3C00, 24'h3C3C5A, 1'b0};
        vecs[6] = '{1'b0, 3'd0, 8'h00, {3'd7, 3'd7, 3'd1}, 16'h3C5A, 24'h3C3C5A, 1'b0};
        vecs[7] = '{1'b1, 3'd3, 8'hC3, {3'd3, 3'd3, 3'd3}, 16'hA5A5, 24'hC3C3C3, 1'b0};
        vecs[8] = '{1'b0, 3'd0, 8'h00, {3'd1, 3'd3, 3'd7}, 16'hC33C, 24'h5AC33C, 1'b0};

        // Reset for two posedges, then release and time the clear
        phase = "reset";
        @(negedge clk);
        @(negedge clk);
        exp_status(1'b0, 1'b0);
        check_all();

        phase = "init_clear";
        reset_n = 1'b1;
        ra = {3'd1, 3'd2, 3'd3};
        for (int k = 0; k < 8; k++) begin
            exp_status(1'b0, 1'b0);
            exp_reads(16'h0000, 24'h000000);
            check_all();
            step();
        end
        exp_status(1'b1, 1'b0);
        exp_reads(16'h0000, 24'h000000);
        check_all();

        // Table-driven write/read, bypass, zero register, concurrent ports
        phase = "table";
        for (int i = 0; i < 9; i++) begin
            regwrite = vecs[i].we;
            wa       = vecs[i].wa;
            wd       = vecs[i].wd;
            ra       = vecs[i].ra;
            exp_reads(vecs[i].rd0, vecs[i].rd1);
            exp_status(1'b1, vecs[i].drop);
            check_all();
            step();
        end
        regwrite = 1'b0;

        // Fill 1..7 with 10..16, then clear with a simultaneous write to 2
        phase = "fill";
        for (int r = 1; r < 8; r++) begin
            regwrite = 1'b1;
            wa       = 3'(r);
            wd       = 8'h0F + 8'(r);
            step();
        end
        regwrite = 1'b0;
        ra = {3'd7, 3'd4, 3'd1};
        exp_reads(16'h1310, 24'h161310);
        exp_status(1'b1, 1'b0);
        check_all();

        phase = "clr_req";
        clr_req  = 1'b1;
        regwrite = 1'b1;
        wa       = 3'd2;
        wd       = 8'h99;
        step();
        clr_req = 1'b0;
        wa      = 3'd5;
        wd      = 8'h11;
        ra      = {3'd2, 3'd5, 3'd2};
        exp_status(1'b0, 1'b0);
        exp_reads(16'h0000, 24'h000000);
        check_all();
        step();
        regwrite = 1'b0;
        exp_status(1'b0, 1'b1);
        check_all();
        step();
        for (int k = 2; k < 8; k++) begin
            exp_status(1'b0, 1'b0);
            exp_reads(16'h0000, 24'h000000);
            check_all();
            step();
        end
        exp_status(1'b1, 1'b0);
        exp_reads(16'h0000, 24'h000000);
        check_all();
        ra = {3'd1, 3'd7, 3'd3};
        exp_reads(16'h0000, 24'h000000);
        check_all();

        // Reset at clear cycle 4 restarts the clear; clr_req during clear ignored
        phase = "reset_mid_clear";
        regwrite = 1'b1;
        wa       = 3'd4;
        wd       = 8'hAA;
        step();
        regwrite = 1'b0;
        ra = {3'd4, 3'd4, 3'd4};
        exp_reads(16'hAAAA, 24'hAAAAAA);
        check_all();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_status(1'b0, 1'b0);
            check_all();
            step();
        end
        reset_n  = 1'b0;
        regwrite = 1'b1;
        wa       = 3'd6;
        wd       = 8'hEE;
        step();
        reset_n  = 1'b1;
        regwrite = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clr_req = (k == 3) ? 1'b1 : 1'b0;
            exp_status(1'b0, 1'b0);
            check_all();
            step();
        end
        clr_req = 1'b0;
        ra = {3'd4, 3'd6, 3'd4};
        exp_status(1'b1, 1'b0);
        exp_reads(16'h0000, 24'h000000);
        check_all();

        // Three ports reading the same register concurrently, with and without bypass
        phase = "concurrent";
        regwrite = 1'b1;
        wa       = 3'd7;
        wd       = 8'h77;
        ra       = {3'd7, 3'd7, 3'd1};
        exp_reads(16'h0000, 24'h777700);
        check_all();
        step();
        regwrite = 1'b0;
        exp_reads(16'h7700, 24'h777700);
        exp_status(1'b1, 1'b0);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
